// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes and the master bridge FSM states.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RESP
    } bridge_state_e;

    // EXOKAY is not an error for a single-beat lite initiator.
    function automatic logic resp_is_error(input axil_resp_e resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// AXI-Lite initiator: converts a single-outstanding valid/ready request port into
// AXI-Lite read/write transactions and returns read data plus a slave-error flag.
module axil_master_bridge
    import axil_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,

    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,

    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,

    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    bridge_state_e         r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;

    logic                  w_aw_done;
    logic                  w_w_done;

    // A channel is done once its valid has dropped or it handshakes this cycle.
    assign w_aw_done = !r_awvalid || m_axil_awready;
    assign w_w_done  = !r_wvalid  || m_axil_wready;

    always_ff @(posedge aclk) begin
        // NOTE: reset is sampled on the clock edge and every register uses <= so
        // all state updates see the values from before this edge.
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_wstrb <= req_wstrb;
                        if (req_write) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_ADDR_DATA;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (m_axil_awready) r_awvalid <= 1'b0;
                    if (m_axil_wready)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axil_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_error <= resp_is_error(axil_resp_e'(m_axil_bresp));
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axil_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axil_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= m_axil_rdata;
                        r_rsp_error <= resp_is_error(axil_resp_e'(m_axil_rresp));
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_awvalid   <= 1'b0;
                    r_wvalid    <= 1'b0;
                    r_bready    <= 1'b0;
                    r_arvalid   <= 1'b0;
                    r_rready    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = (r_state == ST_IDLE);

    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_error      = r_rsp_error;

    assign m_axil_awaddr  = r_addr;
    assign m_axil_awprot  = PROT;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = r_addr;
    assign m_axil_arprot  = PROT;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Directed bench for axil_master_bridge: behavioural AXI-Lite slave with programmable
// ready/valid delays, response scoreboard and cycle-level protocol checks.
module tb_axil_master_bridge;
    import axil_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic [3:0]  m_axil_wstrb;
    logic [1:0]  m_axil_bresp, m_axil_rresp;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;

    always #5 aclk = ~aclk;

    axil_master_bridge dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t mon_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural AXI-Lite slave ----------------
    int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
    logic [1:0]  force_bresp = OKAY, force_rresp = OKAY;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          aw_hs = 0, w_hs = 0, b_hs = 0;
    logic        s_aw_have, s_w_have, b_pend, r_pend;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [0:255];

    initial for (int i = 0; i < 256; i++) mem[i] = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
        return res;
    endfunction

    assign m_axil_awready = (aw_cnt >= aw_delay);
    assign m_axil_wready  = (w_cnt >= w_delay);
    assign m_axil_arready = (ar_cnt >= ar_delay);
    assign m_axil_bvalid  = b_pend && (b_cnt >= b_delay);
    assign m_axil_bresp   = force_bresp;
    assign m_axil_rvalid  = r_pend && (r_cnt >= r_delay);
    assign m_axil_rresp   = force_rresp;
    assign m_axil_rdata   = r_pend ? mem[s_araddr[9:2]] : '0;

    always @(posedge aclk) begin
        if (!aresetn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            s_aw_have <= 1'b0; s_w_have <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            if (m_axil_awvalid && m_axil_awready) begin
                s_awaddr <= m_axil_awaddr; s_aw_have <= 1'b1; aw_cnt <= 0; aw_hs <= aw_hs + 1;
            end else if (m_axil_awvalid) aw_cnt <= aw_cnt + 1;
            if (m_axil_wvalid && m_axil_wready) begin
                s_wdata <= m_axil_wdata; s_wstrb <= m_axil_wstrb; s_w_have <= 1'b1;
                w_cnt <= 0; w_hs <= w_hs + 1;
            end else if (m_axil_wvalid) w_cnt <= w_cnt + 1;
            if (s_aw_have && s_w_have && !b_pend) begin
                mem[s_awaddr[9:2]] <= merge(mem[s_awaddr[9:2]], s_wdata, s_wstrb);
                s_aw_have <= 1'b0; s_w_have <= 1'b0; b_pend <= 1'b1; b_cnt <= 0;
            end
            if (b_pend) begin
                if (m_axil_bvalid && m_axil_bready) begin b_pend <= 1'b0; b_hs <= b_hs + 1; end
                else b_cnt <= b_cnt + 1;
            end
            if (m_axil_arvalid && m_axil_arready) begin
                s_araddr <= m_axil_araddr; r_pend <= 1'b1; r_cnt <= 0; ar_cnt <= 0;
            end else if (m_axil_arvalid) ar_cnt <= ar_cnt + 1;
            if (r_pend) begin
                if (m_axil_rvalid && m_axil_rready) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
        end
    end

    // Response monitor: sampled mid-cycle, compared against the scoreboard.
    always @(negedge aclk) begin
        if (aresetn && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 1'b0);
            else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
                check("rsp_error", rsp_error, mon_e.err);
            end
        end
    end

    // Called and returns at #1 after a posedge; returns #1 after the accept edge.
    task automatic issue_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [31:0] exp_rdata,
                             input logic exp_err, input logic push);
        int t = 0;
        while (!req_ready && t < 100) begin @(posedge aclk); #1; t++; end
        check("req_ready_before_issue", req_ready, 1'b1);
        if (push) exp_q.push_back('{exp_rdata, exp_err});
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data; req_wstrb = strb;
        @(posedge aclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin @(posedge aclk); #1; t++; end
        check(tag, exp_q.size(), 0);
    endtask

    int aw0, w0, b0, t;

    initial begin
        aresetn = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(posedge aclk); #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_awvalid", m_axil_awvalid, 1'b0);
        check("rst_wvalid", m_axil_wvalid, 1'b0);
        check("rst_arvalid", m_axil_arvalid, 1'b0);
        check("rst_bready", m_axil_bready, 1'b0);
        check("rst_rready", m_axil_rready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_error", rsp_error, 1'b0);
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Full-word write then read back.
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        issue_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1);
        check("wr1_awprot", m_axil_awprot, 3'b000);
        wait_done("wr1_done");
        check("wr1_aw_count", aw_hs - aw0, 1);
        check("wr1_w_count", w_hs - w0, 1);
        check("wr1_b_count", b_hs - b0, 1);
        issue_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        wait_done("rd1_done");

        // Partial strobe: only byte 1 replaced.
        issue_req(1'b1, 32'h10, 32'h0000AB00, 4'b0010, 32'h0, 1'b0, 1'b1);
        wait_done("wr2_done");
        issue_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADABEF, 1'b0, 1'b1);
        wait_done("rd2_done");

        // awready delayed 3 cycles, wready immediate.
        aw_delay = 3; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        issue_req(1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b1);
        check("wr3_c1_awvalid", m_axil_awvalid, 1'b1);
        check("wr3_c1_wvalid", m_axil_wvalid, 1'b1);
        @(posedge aclk); #1;
        check("wr3_c2_wvalid", m_axil_wvalid, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            check("wr3_awvalid_held", m_axil_awvalid, 1'b1);
            check("wr3_awaddr_stable", m_axil_awaddr, 32'h20);
            @(posedge aclk); #1;
        end
        check("wr3_c5_awvalid", m_axil_awvalid, 1'b0);
        wait_done("wr3_done");
        check("wr3_aw_count", aw_hs - aw0, 1);
        check("wr3_w_count", w_hs - w0, 1);
        check("wr3_b_count", b_hs - b0, 1);
        aw_delay = 0;

        // Write completing with DECERR.
        force_bresp = DECERR;
        issue_req(1'b1, 32'h50, 32'h55AA55AA, 4'hF, 32'h0, 1'b1, 1'b1);
        wait_done("wr_decerr_done");
        force_bresp = OKAY;

        // Read with SLVERR, plus zero-wait latency.
        issue_req(1'b1, 32'h30, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b1);
        wait_done("wr4_done");
        force_rresp = SLVERR;
        issue_req(1'b0, 32'h30, 32'h0, 4'h0, 32'h12345678, 1'b1, 1'b1);
        check("rd4_c1_arvalid", m_axil_arvalid, 1'b1);
        check("rd4_c1_araddr", m_axil_araddr, 32'h30);
        @(posedge aclk); #1;
        check("rd4_c2_arvalid", m_axil_arvalid, 1'b0);
        check("rd4_c2_rready", m_axil_rready, 1'b1);
        @(posedge aclk); #1;
        check("rd4_c3_rsp_valid", rsp_valid, 1'b1);
        wait_done("rd4_done");
        force_rresp = EXOKAY;
        issue_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADABEF, 1'b0, 1'b1);
        wait_done("rd_exokay_done");
        force_rresp = OKAY;

        // Consumer stalls the response; a queued request must wait.
        rsp_ready = 1'b0;
        issue_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADABEF, 1'b0, 1'b1);
        t = 0;
        while (!rsp_valid && t < 50) begin @(posedge aclk); #1; t++; end
        check("stall_rsp_arrives", rsp_valid, 1'b1);
        exp_q.push_back('{32'h11223344, 1'b0});
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20;
        repeat (5) begin
            @(posedge aclk); #1;
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rsp_rdata", rsp_rdata, 32'hDEADABEF);
            check("stall_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge aclk); #1;
        t = 0;
        while (!req_ready && t < 20) begin @(posedge aclk); #1; t++; end
        check("stall_release_ready", req_ready, 1'b1);
        @(posedge aclk); #1;
        req_valid = 1'b0;
        wait_done("stall_done");

        // Reset while awvalid waits on awready.
        aw_delay = 10;
        issue_req(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0);
        @(posedge aclk); #1;
        check("rst6_awvalid_waiting", m_axil_awvalid, 1'b1);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check("rst6_awvalid", m_axil_awvalid, 1'b0);
        check("rst6_wvalid", m_axil_wvalid, 1'b0);
        check("rst6_arvalid", m_axil_arvalid, 1'b0);
        check("rst6_bready", m_axil_bready, 1'b0);
        check("rst6_rsp_valid", rsp_valid, 1'b0);
        check("rst6_req_ready", req_ready, 1'b1);
        aresetn = 1'b1; aw_delay = 0;
        repeat (3) @(posedge aclk); #1;
        check("rst6_no_rsp", rsp_valid, 1'b0);
        issue_req(1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
        wait_done("rst6_rd_dropped");
        issue_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADABEF, 1'b0, 1'b1);
        wait_done("rst6_rd_done");

        repeat (5) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
